// File: rtl/hub75_pkg.sv
// ============================================================================
// Module : hub75_pkg
// Brief  : Shared types and constants for the HUB75 frame buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hub75_pkg;

    localparam int BPP_DEF = 8;

    typedef logic [2:0][BPP_DEF-1:0] rgb_t;

    localparam int R_IDX = 0;
    localparam int G_IDX = 1;
    localparam int B_IDX = 2;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DONE = 2'd2
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/hub75_framebuf_bank_ram.sv
// ============================================================================
// Module : hub75_bank_ram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hub75_bank_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

`default_nettype wire

// File: rtl/hub75_framebuf.sv
// ============================================================================
// Module : hub75_framebuf
// Brief  : Double-buffered HUB75 frame store; raster writes into the back bank,
//          all panel segments of the front bank read in parallel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hub75_framebuf
    import hub75_pkg::*;
#(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_px_valid,
    output logic                                      o_px_ready,
    input  logic                                      i_px_sof,
    input  logic [2:0][bpp_p-1:0]                     i_px_data,
    input  logic [$clog2(hpixel_p*vpixel_p)-1:0]      i_rd_addr,
    output logic [segments_p-1:0][2:0][bpp_p-1:0]     o_rd_data,
    input  logic                                      i_disp_frame_done,
    output logic                                      o_frame_pending,
    output logic                                      o_front_bank,
    output logic                                      o_sof_err
);

    localparam int rows_seg_p   = vpixel_p / segments_p;
    localparam int seg_depth_p  = hpixel_p * rows_seg_p;
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p);
    localparam int SEG_AW       = $clog2(seg_depth_p);
    localparam int X_W          = $clog2(hpixel_p);
    localparam int Y_W          = $clog2(vpixel_p);
    localparam int PX_W         = 3 * bpp_p;

    wr_state_t          state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               front_q, front_d;
    logic               sof_err_q, sof_err_d;
    logic               rd_bank_q;
    logic               rd_valid_q;

    logic               w_xfer;
    logic               w_we;
    logic [X_W-1:0]     w_wr_x;
    logic [Y_W-1:0]     w_wr_y;
    logic [Y_W-1:0]     w_seg;
    logic [Y_W-1:0]     w_row;
    logic [addr_width_p-1:0] w_waddr;
    logic               w_rd_in_range;
    logic               unused_waddr_hi;

    assign o_px_ready      = (state_q != WR_DONE);
    assign o_frame_pending = (state_q == WR_DONE);
    assign o_front_bank    = front_q;
    assign o_sof_err       = sof_err_q;
    assign w_xfer          = i_px_valid & o_px_ready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        front_d   = front_q;
        sof_err_d = 1'b0;
        w_we      = 1'b0;
        w_wr_x    = x_q;
        w_wr_y    = y_q;
        case (state_q)
            WR_IDLE: begin
                if (w_xfer && i_px_sof) begin
                    w_we    = 1'b1;
                    w_wr_x  = '0;
                    w_wr_y  = '0;
                    x_d     = X_W'(1);
                    y_d     = '0;
                    state_d = WR_FILL;
                end
            end
            WR_FILL: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    // A stray SOF restarts the frame at the origin.
                    if (i_px_sof && (x_q != '0 || y_q != '0)) begin
                        sof_err_d = 1'b1;
                        w_wr_x    = '0;
                        w_wr_y    = '0;
                        x_d       = X_W'(1);
                        y_d       = '0;
                    end else if (x_q == X_W'(hpixel_p - 1)) begin
                        x_d = '0;
                        if (y_q == Y_W'(vpixel_p - 1)) begin
                            y_d     = '0;
                            state_d = WR_DONE;
                        end else begin
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            WR_DONE: begin
                if (i_disp_frame_done) begin
                    front_d = ~front_q;
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WR_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            front_q    <= 1'b0;
            sof_err_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            front_q    <= front_d;
            sof_err_q  <= sof_err_d;
            rd_bank_q  <= front_q;
            rd_valid_q <= w_rd_in_range;
        end
    end

    assign w_seg   = w_wr_y / Y_W'(rows_seg_p);
    assign w_row   = w_wr_y % Y_W'(rows_seg_p);
    assign w_waddr = addr_width_p'(w_row) * addr_width_p'(hpixel_p) + addr_width_p'(w_wr_x);
    assign unused_waddr_hi = ^w_waddr[addr_width_p-1:SEG_AW];
    assign w_rd_in_range   = (i_rd_addr < addr_width_p'(seg_depth_p));

    logic [PX_W-1:0] w_rdata [2][segments_p];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar s = 0; s < segments_p; s++) begin : g_seg
            hub75_bank_ram #(
                .DEPTH (seg_depth_p),
                .WIDTH (PX_W)
            ) u_ram (
                .clk     (clk),
                .we_i    (w_we && (front_q != 1'(b)) && (w_seg == Y_W'(s))),
                .waddr_i (w_waddr[SEG_AW-1:0]),
                .wdata_i (i_px_data),
                .raddr_i (i_rd_addr[SEG_AW-1:0]),
                .rdata_o (w_rdata[b][s])
            );
        end
    end

    for (genvar s = 0; s < segments_p; s++) begin : g_rd_mux
        assign o_rd_data[s] = !rd_valid_q ? '0 :
                              (rd_bank_q ? w_rdata[1][s] : w_rdata[0][s]);
    end

endmodule

`default_nettype wire

// File: tb/tb_hub75_framebuf.sv
// ============================================================================
// Module : tb_hub75_framebuf
// Brief  : Self-checking bench for hub75_framebuf against a pixel-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hub75_framebuf;

    localparam int HP  = 64;
    localparam int VP  = 64;
    localparam int RS  = 32;
    localparam int SD  = 2048;
    localparam int NPX = HP * VP;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_px_valid = 1'b0;
    logic               o_px_ready;
    logic               i_px_sof = 1'b0;
    logic [2:0][7:0]    i_px_data = '0;
    logic [11:0]        i_rd_addr = '0;
    logic [1:0][2:0][7:0] o_rd_data;
    logic               i_disp_frame_done = 1'b0;
    logic               o_frame_pending;
    logic               o_front_bank;
    logic               o_sof_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int rd_ctr = 0;

    always #5 clk = ~clk;

    hub75_framebuf dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_px_valid        (i_px_valid),
        .o_px_ready        (o_px_ready),
        .i_px_sof          (i_px_sof),
        .i_px_data         (i_px_data),
        .i_rd_addr         (i_rd_addr),
        .o_rd_data         (o_rd_data),
        .i_disp_frame_done (i_disp_frame_done),
        .o_frame_pending   (o_frame_pending),
        .o_front_bank      (o_front_bank),
        .o_sof_err         (o_sof_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pxv(input int tag, input int idx);
        return {8'(tag), 8'(idx / HP), 8'(idx % HP)};
    endfunction

    // Model: two banks of raster-indexed pixels, frame position counter.
    logic [23:0] mmem   [2][NPX];
    bit          mknown [2][NPX];
    int          mstate;
    int          mpos;
    bit          mfront;
    bit          exp_err;
    bit          rd_known;
    logic [1:0][23:0] exp_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate   = 0;
            mpos     = 0;
            mfront   = 1'b0;
            exp_err  = 1'b0;
            exp_rd   = '0;
            rd_known = 1'b1;
        end else begin
            exp_err  = 1'b0;
            rd_known = 1'b1;
            if (int'(i_rd_addr) < SD) begin
                for (int s = 0; s < 2; s++) begin
                    int idx;
                    idx = (s * RS + int'(i_rd_addr) / HP) * HP + int'(i_rd_addr) % HP;
                    if (mknown[mfront][idx]) exp_rd[s] = mmem[mfront][idx];
                    else rd_known = 1'b0;
                end
            end else begin
                exp_rd = '0;
            end
            case (mstate)
                0: if (i_px_valid && i_px_sof) begin
                    mmem[!mfront][0] = i_px_data;
                    mknown[!mfront][0] = 1'b1;
                    mpos = 1;
                    mstate = 1;
                end
                1: if (i_px_valid) begin
                    if (i_px_sof && mpos != 0) begin
                        exp_err = 1'b1;
                        mmem[!mfront][0] = i_px_data;
                        mknown[!mfront][0] = 1'b1;
                        mpos = 1;
                    end else begin
                        mmem[!mfront][mpos] = i_px_data;
                        mknown[!mfront][mpos] = 1'b1;
                        mpos++;
                        if (mpos == NPX) mstate = 2;
                    end
                end
                default: if (i_disp_frame_done) begin
                    mfront = !mfront;
                    mstate = 0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("px_ready", 64'(o_px_ready), 64'(mstate != 2));
        chk("frame_pending", 64'(o_frame_pending), 64'(mstate == 2));
        chk("front_bank", 64'(o_front_bank), 64'(mfront));
        chk("sof_err", 64'(o_sof_err), 64'(exp_err));
        if (rd_known) chk("rd_data", 64'(o_rd_data), 64'(exp_rd));
        if (o_sof_err) err_seen++;
    end

    task automatic drive(input bit v, input bit sof, input logic [23:0] d,
                         input bit done, input int addr);
        @(negedge clk);
        i_px_valid        = v;
        i_px_sof          = sof;
        i_px_data         = d;
        i_disp_frame_done = done;
        if (addr < 0) begin
            rd_ctr    = (rd_ctr + 37) % 2100;
            i_rd_addr = 12'(rd_ctr);
        end else begin
            i_rd_addr = 12'(addr);
        end
        @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", 64'(o_px_ready), 64'd1);
        chk("reset_pending", 64'(o_frame_pending), 64'd0);
        chk("reset_front", 64'(o_front_bank), 64'd0);
        chk("reset_rd_data", 64'(o_rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) drive(1, 0, pxv(7, i), 0, -1);
        #2;
        chk("nosof_pending", 64'(o_frame_pending), 64'd0);
        chk("nosof_ready", 64'(o_px_ready), 64'd1);

        for (int i = 0; i < NPX; i++) drive(1, i == 0, pxv(1, i), 0, -1);
        #2;
        chk("frameA_pending", 64'(o_frame_pending), 64'd1);
        chk("frameA_ready", 64'(o_px_ready), 64'd0);
        chk("frameA_front", 64'(o_front_bank), 64'd0);

        repeat (3) drive(1, 0, pxv(9, 0), 0, -1);
        #2;
        chk("stall_pending", 64'(o_frame_pending), 64'd1);

        drive(0, 0, '0, 1, 5);
        #2;
        chk("swap1_front", 64'(o_front_bank), 64'd1);
        chk("swap1_pending", 64'(o_frame_pending), 64'd0);
        drive(0, 0, '0, 0, 5);
        #2;
        chk("addr5_frameA", 64'(o_rd_data), 64'h012005_010005);
        drive(0, 0, '0, 0, 3000);
        #2;
        chk("addr_oob_zero", 64'(o_rd_data), 64'd0);

        err_seen = 0;
        for (int i = 0; i < 100; i++) drive(1, i == 0, pxv(9, i), 0, -1);
        for (int i = 0; i < NPX - 1; i++) drive(1, i == 0, pxv(2, i), 0, -1);
        #2;
        chk("midsof_err_count", 64'(err_seen), 64'd1);
        chk("midsof_no_early_pending", 64'(o_frame_pending), 64'd0);
        drive(1, 0, pxv(2, NPX - 1), 1, -1);
        #2;
        chk("lastpx_done_pending", 64'(o_frame_pending), 64'd1);
        chk("lastpx_done_noswap", 64'(o_front_bank), 64'd1);
        drive(0, 0, '0, 0, -1);
        drive(0, 0, '0, 1, 5);
        #2;
        chk("swap2_front", 64'(o_front_bank), 64'd0);
        chk("swap2_old_bank", 64'(o_rd_data), 64'h012005_010005);
        drive(0, 0, '0, 0, 5);
        #2;
        chk("swap2_new_bank", 64'(o_rd_data), 64'h022005_020005);

        for (int i = 0; i < 50; i++) drive(1, i == 0, pxv(3, i), 0, -1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_front", 64'(o_front_bank), 64'd0);
        chk("async_rst_pending", 64'(o_frame_pending), 64'd0);
        chk("async_rst_rd_data", 64'(o_rd_data), 64'd0);
        chk("async_rst_ready", 64'(o_px_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) drive(1, 0, pxv(4, i), 0, -1);
        drive(0, 0, '0, 0, 5);
        #2;
        chk("post_rst_pending", 64'(o_frame_pending), 64'd0);
        chk("post_rst_front_data", 64'(o_rd_data), 64'h022005_020005);
        drive(1, 1, pxv(5, 0), 0, -1);
        drive(0, 0, '0, 0, -1);
        #2;
        chk("restart_ready", 64'(o_px_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
